// File: rtl/wdt_cmd_tx.sv
// Transmit side of the watchdog clock-domain crossing. Turns register writes into
// {op, payload} commands and pushes them into an async FIFO. Repeated writes coalesce.
module wdt_cmd_tx #(
   parameter int DATA_W = 32,
   parameter int CMD_W  = DATA_W + 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en_i,
   input  logic [1:0]        wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   output logic              push_o,
   input  logic              full_i,
   output logic [CMD_W-1:0]  data_o,
   output logic              busy_o,
   output logic [7:0]        coal_cnt_o,
   output logic              addr_err_o
);

   localparam logic [1:0] OP_WDEN   = 2'd0;
   localparam logic [1:0] OP_WDLIVE = 2'd1;
   localparam logic [1:0] OP_WTOCNT = 2'd2;
   localparam logic [1:0] ADDR_RSVD = 2'd3;

   typedef enum logic {
      S_IDLE,
      S_SEND
   } state_e;

   state_e              state_q;
   logic                push_q;
   logic [CMD_W-1:0]    data_q;
   logic [2:0]          pend_q,      pend_d;
   logic                val_en_q,    val_en_d;
   logic                val_live_q,  val_live_d;
   logic [DATA_W-1:0]   val_cnt_q,   val_cnt_d;
   logic [7:0]          coal_cnt_q,  coal_cnt_d;
   logic                addr_err_q,  addr_err_d;

   logic                wr_valid;
   logic [2:0]          wr_mask;
   logic                accept;
   logic                can_load;
   logic [2:0]          sel_mask;
   logic [2:0]          load_mask;
   logic                load_en;
   logic [CMD_W-1:0]    load_cmd;
   logic                coalesce;

   // NOTE: every signal assigned in this block gets a default first, so no latch can be inferred.
   always_comb begin
      wr_valid  = wr_en_i && (wr_addr_i != ADDR_RSVD);
      wr_mask   = wr_valid ? (3'b001 << wr_addr_i) : 3'b000;
      accept    = push_q && !full_i;
      can_load  = (state_q == S_IDLE) || accept;

      // WTOCNT before WDEN so the timeout is in place before the watchdog is enabled.
      sel_mask  = 3'b000;
      load_cmd  = '0;
      if (pend_q[OP_WTOCNT]) begin
         sel_mask = 3'b100;
         load_cmd = {OP_WTOCNT, val_cnt_q};
      end else if (pend_q[OP_WDEN]) begin
         sel_mask = 3'b001;
         load_cmd = {OP_WDEN, {(DATA_W-1){1'b0}}, val_en_q};
      end else if (pend_q[OP_WDLIVE]) begin
         sel_mask = 3'b010;
         load_cmd = {OP_WDLIVE, {(DATA_W-1){1'b0}}, val_live_q};
      end

      load_mask = can_load ? sel_mask : 3'b000;
      load_en   = |load_mask;

      // A write racing the load of the same register sets pend again: re-send, not a coalesce.
      coalesce  = |(wr_mask & pend_q & ~load_mask);
      pend_d    = (pend_q & ~load_mask) | wr_mask;

      val_en_d   = wr_mask[OP_WDEN]   ? wr_data_i[0] : val_en_q;
      val_live_d = wr_mask[OP_WDLIVE] ? wr_data_i[0] : val_live_q;
      val_cnt_d  = wr_mask[OP_WTOCNT] ? wr_data_i    : val_cnt_q;

      coal_cnt_d = coal_cnt_q;
      if (coalesce && (coal_cnt_q != 8'hFF)) begin
         coal_cnt_d = coal_cnt_q + 8'd1;
      end

      addr_err_d = wr_en_i && (wr_addr_i == ADDR_RSVD);
   end

   // NOTE: the value registers are plain flops, not a memory, so they are cleared by reset too.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         push_q     <= 1'b0;
         data_q     <= '0;
         pend_q     <= 3'b000;
         val_en_q   <= 1'b0;
         val_live_q <= 1'b0;
         val_cnt_q  <= '0;
         coal_cnt_q <= 8'd0;
         addr_err_q <= 1'b0;
      end else begin
         pend_q     <= pend_d;
         val_en_q   <= val_en_d;
         val_live_q <= val_live_d;
         val_cnt_q  <= val_cnt_d;
         coal_cnt_q <= coal_cnt_d;
         addr_err_q <= addr_err_d;

         case (state_q)
            S_IDLE: begin
               if (load_en) begin
                  data_q  <= load_cmd;
                  push_q  <= 1'b1;
                  state_q <= S_SEND;
               end
            end
            S_SEND: begin
               // data_q only changes on an accept, keeping it stable under backpressure.
               if (accept) begin
                  if (load_en) begin
                     data_q <= load_cmd;
                  end else begin
                     push_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end
            end
            default: begin
               push_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign push_o     = push_q;
   assign data_o     = data_q;
   assign busy_o     = push_q | (|pend_q);
   assign coal_cnt_o = coal_cnt_q;
   assign addr_err_o = addr_err_q;

endmodule

// File: tb/tb_wdt_cmd_tx.sv
// Scoreboard bench for wdt_cmd_tx: stimulus queues expected commands, a negedge
// monitor pops one per accept and also checks push/data stability under backpressure.
module tb_wdt_cmd_tx;

   localparam int DATA_W = 32;
   localparam int CMD_W  = DATA_W + 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_en;
   logic [1:0]        wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              full;
   logic              push;
   logic [CMD_W-1:0]  data;
   logic              busy;
   logic [7:0]        coal;
   logic              addr_err;

   int checks = 0;
   int errors = 0;
   int acc_cnt = 0;
   int cyc = 0;
   int acc_cyc[$];
   logic [CMD_W-1:0] exp_q[$];

   logic             prev_hold = 1'b0;
   logic [CMD_W-1:0] prev_data = '0;

   wdt_cmd_tx #(.DATA_W(DATA_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en_i    (wr_en),
      .wr_addr_i  (wr_addr),
      .wr_data_i  (wr_data),
      .push_o     (push),
      .full_i     (full),
      .data_o     (data),
      .busy_o     (busy),
      .coal_cnt_o (coal),
      .addr_err_o (addr_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every accept, checks held commands stay put.
   always @(negedge clk) begin
      if (prev_hold) begin
         check("push_held", push, 1'b1);
         check("data_stable", data, prev_data);
      end
      if (push && !full && !rst) begin
         acc_cnt++;
         acc_cyc.push_back(cyc);
         if (exp_q.size() == 0) check("accept_was_expected", exp_q.size(), 1);
         else check("accept_data", data, exp_q.pop_front());
      end
      prev_hold = push && full && !rst;
      prev_data = data;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [1:0] a, input logic [DATA_W-1:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic wait_push();
      int n = 0;
      while (!push && n < 10) begin
         step();
         n++;
      end
      check("wait_push", push, 1'b1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < 100) begin
         step();
         n++;
      end
      check("drain_busy", busy, 1'b0);
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int a0;
      int n;
      rst     = 1'b1;
      wr_en   = 1'b0;
      wr_addr = 2'd0;
      wr_data = '0;
      full    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_push", push, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_coal", coal, 8'd0);
      check("rst_addr_err", addr_err, 1'b0);
      check("rst_data", data, 34'h0);
      rst = 1'b0;

      // Basic write: latency of two cycles, accept in cycle 2.
      exp_q.push_back({2'b10, 32'h0000_1234});
      write(2'd2, 32'h0000_1234);
      check("basic_push_c1", push, 1'b0);
      step();
      check("basic_push_c2", push, 1'b1);
      check("basic_data_c2", data, {2'b10, 32'h0000_1234});
      step();
      check("basic_push_c3", push, 1'b0);
      check("basic_busy_c3", busy, 1'b0);
      check("basic_acc_cnt", acc_cnt, 1);

      // Backpressure: ten held cycles, then exactly one accept.
      full = 1'b1;
      exp_q.push_back({2'b00, 32'h1});
      write(2'd0, 32'h1);
      wait_push();
      repeat (10) step();
      a0 = acc_cnt;
      full = 1'b0;
      repeat (3) step();
      check("bp_one_accept", acc_cnt, a0 + 1);
      check("bp_push_low", push, 1'b0);

      // Priority and back-to-back.
      full = 1'b1;
      exp_q.push_back({2'b01, 32'h1});
      exp_q.push_back({2'b10, 32'h50});
      exp_q.push_back({2'b00, 32'h1});
      write(2'd1, 32'h1);
      write(2'd0, 32'h1);
      write(2'd2, 32'h50);
      step();
      check("prio_busy", busy, 1'b1);
      full = 1'b0;
      wait_idle();
      n = acc_cyc.size();
      check("b2b_gap_a", acc_cyc[n-2] - acc_cyc[n-3], 1);
      check("b2b_gap_b", acc_cyc[n-1] - acc_cyc[n-2], 1);

      // Coalescing: newest WTOCNT value wins, two overwrites counted.
      full = 1'b1;
      exp_q.push_back({2'b01, 32'h1});
      exp_q.push_back({2'b10, 32'h30});
      write(2'd1, 32'h1);
      wait_push();
      write(2'd2, 32'h10);
      write(2'd2, 32'h20);
      write(2'd2, 32'h30);
      check("coal_cnt_2", coal, 8'd2);
      full = 1'b0;
      wait_idle();

      // Saturation: 300 more coalesces.
      full = 1'b1;
      exp_q.push_back({2'b01, 32'h1});
      exp_q.push_back({2'b10, 32'd300});
      write(2'd1, 32'h1);
      wait_push();
      for (int i = 0; i <= 300; i++) write(2'd2, 32'(i));
      check("coal_cnt_sat", coal, 8'd255);
      full = 1'b0;
      wait_idle();
      check("coal_cnt_sat_hold", coal, 8'd255);

      // Same-cycle load of WDEN=0 while WDEN=1 is written.
      do_reset();
      check("coal_after_reset", coal, 8'd0);
      exp_q.push_back({2'b00, 32'h0});
      exp_q.push_back({2'b00, 32'h1});
      write(2'd0, 32'h0);
      write(2'd0, 32'h1);
      wait_idle();
      check("same_cycle_no_coal", coal, 8'd0);

      // Reset mid-handshake drops the held command and clears everything.
      full = 1'b1;
      write(2'd1, 32'h1);
      wait_push();
      write(2'd2, 32'h7);
      write(2'd2, 32'h8);
      check("pre_rst_coal", coal, 8'd1);
      a0 = acc_cnt;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid_rst_push", push, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_coal", coal, 8'd0);
      full = 1'b0;
      repeat (5) step();
      check("mid_rst_no_accept", acc_cnt, a0);

      // Reserved address: one-cycle error pulse, nothing queued.
      write(2'd3, 32'hFFFF_FFFF);
      check("rsvd_err_hi", addr_err, 1'b1);
      check("rsvd_busy", busy, 1'b0);
      step();
      check("rsvd_err_lo", addr_err, 1'b0);
      check("rsvd_busy_2", busy, 1'b0);
      repeat (3) step();
      check("rsvd_no_accept", acc_cnt, a0);
      check("final_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
